cyq_seg_scan: RTL and testbench
===============================

# cyq_seg_scan

Parametrised, time-multiplexed 7-segment display driver. It is the sequential successor to the single-digit 74HC4511-style decoder. It latches a packed multi-digit BCD/hex word, scans the digits one at a time with a programmable dwell, and keeps the 4511 lamp-test and blanking controls. It adds tear-free frame-synchronous updates, leading-zero blanking and an optional hex mode. It sits between the datapath and the board's common-cathode digit/segment pins.

## Interface
Parameters:
- DIGITS, 4: number of scanned digits, legal 2..8.
- DIV, 1000: clocks per digit dwell, legal ≥1.
- HEX, 1: 1 = codes 10–15 shown as A,b,C,d,E,F; 0 = codes 10–15 blanked (4511 behaviour).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld  in  1  one-cycle strobe; capture d and dp_in into the shadow register.
- d  in  4*DIGITS  packed digit values; d[3:0] = digit 0 (least significant).
- dp_in  in  DIGITS  decimal point per digit.
- lt  in  1  lamp test, active-low.
- bi  in  1  blanking, active-low.
- lzb  in  1  leading-zero blanking enable.
- seg  out  7  segments, active-high; seg[6]=a … seg[0]=g.
- dp  out  1  decimal point, active-high.
- an  out  DIGITS  one-hot digit enable, active-high.
- frame  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Prescaler `pc` counts 0..DIV-1. A tick occurs when pc==DIV-1; pc then returns to 0.
- On a tick, digit index `idx` (width $clog2(DIGITS)) advances. idx wraps from DIGITS-1 to 0; that tick is the frame wrap.
- ld: shadow <= {d, dp_in}, and `pend` is set. ld may be asserted at any time.
- Frame wrap with pend=1: disp <= shadow, pend <= 0. The displayed word only changes at a frame boundary.
- ld in the same cycle as a frame wrap: disp <= {d, dp_in} directly, and pend stays 0.
- Digit value v = disp nibble [idx].
- Zero suppression: digit i is suppressed if lzb=1, i≠0, and all of disp digits DIGITS-1..i are 0. Digit 0 is never suppressed. dp is not affected by suppression.
- Output priority, evaluated in order:
  - lt=0: seg=7'h7F, dp=1, an=onehot(idx). Lamp test dominates bi.
  - bi=0: seg=0, dp=0, an=0.
  - Otherwise: an=onehot(idx) and dp=disp_dp[idx]. seg=0 if the digit is suppressed, or if v≥10 and HEX=0; else seg=decode(v).
- Scanning continues during lamp test and blanking.

## Timing
- Reset (async, any time, including mid-frame): pc=0, idx=0, pend=0, shadow=0, disp=0, seg=0, dp=0, an=0, frame=0.
- First rising edge after rst deasserts: an=onehot(0), seg=decode(0)=7'b1111110 (lt=1, bi=1, lzb=0).
- seg, dp, an and frame are registered. They are computed from the next-state idx and disp, so they change on the same edge as idx. There is no skew between an and seg.
- lt, bi and lzb are sampled each cycle, so a change is visible on the next edge.
- frame=1 for exactly the one cycle following a frame wrap. Frame period is DIGITS*DIV cycles.
- DIV=1: idx advances every cycle, and frame pulses every DIGITS cycles.
- Latency from ld to display: the next frame wrap, at most DIGITS*DIV cycles.

## Structure
- Package cyq_seg_pkg holds the constants SEG_0..SEG_F, SEG_BLANK (7'h00) and SEG_ALL (7'h7F).
- Sub-module cyq_seg_dec: combinational 4-bit→7-seg decoder with a HEX parameter. Instantiated once, driven by the selected nibble.
- Top level holds the prescaler, idx counter, shadow/disp/pend registers, zero-suppression logic, priority mux and output registers.

## Test plan
All scenarios use DIGITS=4, DIV=4, HEX=1 unless stated.
- rst=1 mid-frame with idx=2 → same cycle: an=0000, seg=0, dp=0, frame=0. After release, first edge: an=0001, seg=7'b1111110.
- ld with d=16'h1234 at idx=1 → display unchanged until wrap. Next frame: idx0 seg=7'b0110011 ("4"), idx3 seg=7'b0110000 ("1").
- lzb=1, d=16'h0040 → idx3 and idx2 seg=0 with an still one-hot; idx1 seg="4"; idx0 seg=7'b1111110. With d=0, only idx0 is lit.
- v=4'hA → HEX=1: seg=7'b1110111; HEX=0: seg=0.
- lt=0, bi=0 → seg=7'h7F, dp=1. Then lt=1, bi=0 → seg=0, dp=0, an=0000, while idx keeps scanning.
- frame pulses are 1 cycle wide, 16 cycles apart. ld coincident with the wrap → new value shown at idx0 of that frame.

Source files
------------

// File: rtl/cyq_seg_pkg.sv
// -----------------------------------------------------------------------------
// cyq_seg_pkg
// Shared constants for the multiplexed 7-segment driver.
// Segment patterns are active-high, bit order {a,b,c,d,e,f,g} = seg[6:0].
// -----------------------------------------------------------------------------
package cyq_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7F;

endpackage

// File: rtl/cyq_seg_dec.sv
// -----------------------------------------------------------------------------
// cyq_seg_dec
// Combinational 4-bit to 7-segment decoder.
//   val_i  [3:0]  digit code
//   seg_o  [6:0]  segment pattern, seg_o[6]=a .. seg_o[0]=g
// HEX=1 shows codes 10..15 as A,b,C,d,E,F; HEX=0 blanks them (4511 style).
// -----------------------------------------------------------------------------
module cyq_seg_dec
  import cyq_seg_pkg::*;
#(
  parameter int HEX = 1
) (
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  localparam bit HEX_EN = (HEX != 0);

  always_comb begin
    // NOTE: default first so every path assigns seg_o and no latch is inferred.
    seg_o = SEG_BLANK;
    case (val_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = HEX_EN ? SEG_A : SEG_BLANK;
      4'hB: seg_o = HEX_EN ? SEG_B : SEG_BLANK;
      4'hC: seg_o = HEX_EN ? SEG_C : SEG_BLANK;
      4'hD: seg_o = HEX_EN ? SEG_D : SEG_BLANK;
      4'hE: seg_o = HEX_EN ? SEG_E : SEG_BLANK;
      4'hF: seg_o = HEX_EN ? SEG_F : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cyq_seg_scan.sv
// -----------------------------------------------------------------------------
// cyq_seg_scan
// Time-multiplexed 7-segment display driver for common-cathode displays.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   ld     one-cycle strobe: capture d/dp_in into the shadow register
//   d      packed digits, d[3:0] = digit 0
//   dp_in  decimal point per digit
//   lt     lamp test (active-low), bi blanking (active-low)
//   lzb    leading-zero blanking enable
//   seg    segments a..g (seg[6]=a), dp decimal point, an one-hot digit enable
//   frame  one-cycle pulse following each frame wrap
// The displayed word only changes at a frame wrap, so a frame never tears.
// All outputs are registered from next-state idx/disp so an and seg never skew.
// -----------------------------------------------------------------------------
module cyq_seg_scan
  import cyq_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int HEX    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   d,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lt,
  input  logic                  bi,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      shadow_q, shadow_d, disp_q, disp_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic              pend_q, pend_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d, frame_q, frame_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick, wrap;
  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic [DIGITS-1:0] lead_zero;   // lead_zero[i]: digits DIGITS-1..i all zero
  logic [DIGITS-1:0] onehot;
  logic              suppress;

  // Scan timing and frame-synchronous word update.
  always_comb begin
    tick  = (pc_q == PC_MAX);
    pc_d  = tick ? '0 : pc_q + 1'b1;
    wrap  = tick && (idx_q == IDX_MAX);
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pend_d      = pend_q;
    if (ld) begin
      shadow_d    = d;
      shadow_dp_d = dp_in;
    end
    if (wrap) begin
      // A load coinciding with the wrap bypasses the shadow entirely.
      if (ld) begin
        disp_d    = d;
        disp_dp_d = dp_in;
      end else if (pend_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pend_d = 1'b0;
    end else if (ld) begin
      pend_d = 1'b1;
    end
  end

  // Selected digit and leading-zero chain, both from next-state values.
  always_comb begin
    nib = disp_d[{idx_d, 2'b00} +: 4];
    lead_zero[DIGITS-1] = (disp_d[W-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (disp_d[4*i +: 4] == 4'h0);
    end
    suppress = lzb && (idx_d != '0) && lead_zero[idx_d];
    onehot   = DIGITS'(1) << idx_d;
  end

  cyq_seg_dec #(
    .HEX (HEX)
  ) u_dec (
    .val_i (nib),
    .seg_o (dec_seg)
  );

  // Output priority: lamp test, then blanking, then normal display.
  always_comb begin
    seg_d   = SEG_BLANK;
    dp_d    = 1'b0;
    an_d    = '0;
    frame_d = wrap;
    if (!lt) begin
      seg_d = SEG_ALL;
      dp_d  = 1'b1;
      an_d  = onehot;
    end else if (bi) begin
      an_d  = onehot;
      dp_d  = disp_dp_d[idx_d];
      seg_d = suppress ? SEG_BLANK : dec_seg;
    end
  end

  // NOTE: every register, including the data words, is reset so the pins go
  // dark the moment rst asserts; state updates use non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      an_q        <= '0;
      frame_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_cyq_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_cyq_seg_scan
// Two instances share one set of inputs: unit A (DIGITS=4, DIV=4, HEX=1) and
// unit B (DIGITS=4, DIV=1, HEX=0). A reference model derives idx and frame
// wrap from the number of edges since reset and tracks the displayed word;
// a compare process checks both units every cycle, and the directed part
// pins the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_cyq_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] d = '0;
  logic [3:0]  dp_in = '0;
  logic        lt = 1'b1;
  logic        bi = 1'b1;
  logic        lzb = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fr_a, fr_b;
  logic [3:0]  an_a, an_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cyq_seg_scan #(.DIGITS(4), .DIV(4), .HEX(1)) u_dut_a (
    .clk(clk), .rst(rst), .ld(ld), .d(d), .dp_in(dp_in), .lt(lt), .bi(bi),
    .lzb(lzb), .seg(seg_a), .dp(dp_a), .an(an_a), .frame(fr_a)
  );

  cyq_seg_scan #(.DIGITS(4), .DIV(1), .HEX(0)) u_dut_b (
    .clk(clk), .rst(rst), .ld(ld), .d(d), .dp_in(dp_in), .lt(lt), .bi(bi),
    .lzb(lzb), .seg(seg_b), .dp(dp_b), .an(an_b), .frame(fr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v, input bit hx);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return hx ? 7'b1110111 : 7'h00;
      4'hB: return hx ? 7'b0011111 : 7'h00;
      4'hC: return hx ? 7'b1001110 : 7'h00;
      4'hD: return hx ? 7'b0111101 : 7'h00;
      4'hE: return hx ? 7'b1001111 : 7'h00;
      default: return hx ? 7'b1000111 : 7'h00;
    endcase
  endfunction

  // Reference model state, index 0 = unit A, 1 = unit B.
  int          m_k[2];
  logic [15:0] m_disp[2], m_sh[2];
  logic [3:0]  m_disp_dp[2], m_sh_dp[2];
  bit          m_pend[2];
  logic [6:0]  e_seg[2];
  logic        e_dp[2], e_fr[2];
  logic [3:0]  e_an[2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_k[u] = 0; m_disp[u] = '0; m_sh[u] = '0; m_disp_dp[u] = '0; m_sh_dp[u] = '0;
      m_pend[u] = 0; e_seg[u] = '0; e_dp[u] = 0; e_fr[u] = 0; e_an[u] = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          m_k[u] = 0; m_disp[u] = '0; m_sh[u] = '0; m_disp_dp[u] = '0; m_sh_dp[u] = '0;
          m_pend[u] = 0; e_seg[u] = '0; e_dp[u] = 0; e_fr[u] = 0; e_an[u] = '0;
        end else begin
          int          dv, ix;
          bit          wr, sup;
          logic [15:0] upper;
          dv = (u == 0) ? 4 : 1;
          m_k[u]++;
          ix = (m_k[u] / dv) % 4;
          wr = (m_k[u] % (4 * dv)) == 0;
          if (wr) begin
            if (ld) begin
              m_disp[u] = d; m_disp_dp[u] = dp_in;
            end else if (m_pend[u]) begin
              m_disp[u] = m_sh[u]; m_disp_dp[u] = m_sh_dp[u];
            end
            m_pend[u] = 0;
          end
          if (ld) begin
            m_sh[u] = d; m_sh_dp[u] = dp_in;
            if (!wr) m_pend[u] = 1;
          end
          upper = m_disp[u] >> (4 * ix);
          sup   = lzb && (ix != 0) && (upper == 16'h0);
          e_fr[u] = wr;
          if (!lt) begin
            e_seg[u] = 7'h7F; e_dp[u] = 1'b1; e_an[u] = 4'b0001 << ix;
          end else if (!bi) begin
            e_seg[u] = 7'h00; e_dp[u] = 1'b0; e_an[u] = 4'b0000;
          end else begin
            e_an[u]  = 4'b0001 << ix;
            e_dp[u]  = m_disp_dp[u][ix];
            e_seg[u] = sup ? 7'h00 : seg_ref(upper[3:0], u == 0);
          end
        end
      end
    end
  end

  // Compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("seg_a", seg_a, e_seg[0]);
      check("dp_a", dp_a, e_dp[0]);
      check("an_a", an_a, e_an[0]);
      check("frame_a", fr_a, e_fr[0]);
      check("seg_b", seg_b, e_seg[1]);
      check("dp_b", dp_b, e_dp[1]);
      check("an_b", an_b, e_an[1]);
      check("frame_b", fr_b, e_fr[1]);
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fr_a === 1'b1) got = 1;
    end
    check("frame_seen", got, 1);
  endtask

  initial begin
    int n;
    logic [15:0] rd;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    #2;
    check("rst_an", an_a, 4'b0000);
    check("rst_seg", seg_a, 7'h00);
    check("rst_dp", dp_a, 1'b0);
    check("rst_frame", fr_a, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("first_an", an_a, 4'b0001);
    check("first_seg", seg_a, 7'b1111110);

    // Load 1234 at idx1; visible only from the next frame.
    wait_frame();
    skip(4);
    check("idx1_an", an_a, 4'b0010);
    ld = 1'b1; d = 16'h1234;
    skip(1);
    ld = 1'b0;
    check("no_tear_seg", seg_a, 7'b1111110);
    wait_frame();
    check("ld_idx0_seg", seg_a, 7'b0110011);
    check("ld_idx0_an", an_a, 4'b0001);
    skip(12);
    check("ld_idx3_an", an_a, 4'b1000);
    check("ld_idx3_seg", seg_a, 7'b0110000);

    // Leading-zero blanking on 0040, then 0000.
    lzb = 1'b1; ld = 1'b1; d = 16'h0040;
    skip(1);
    ld = 1'b0;
    wait_frame();
    check("lzb_idx0_seg", seg_a, 7'b1111110);
    skip(4);
    check("lzb_idx1_seg", seg_a, 7'b0110011);
    skip(4);
    check("lzb_idx2_seg", seg_a, 7'h00);
    check("lzb_idx2_an", an_a, 4'b0100);
    skip(4);
    check("lzb_idx3_seg", seg_a, 7'h00);
    check("lzb_idx3_an", an_a, 4'b1000);
    ld = 1'b1; d = 16'h0000;
    skip(1);
    ld = 1'b0;
    wait_frame();
    check("lzb0_idx0_seg", seg_a, 7'b1111110);
    skip(4);
    check("lzb0_idx1_seg", seg_a, 7'h00);

    // Code A: shown on the hex unit, blanked on the 4511-style unit.
    lzb = 1'b0; ld = 1'b1; d = 16'h000A;
    skip(1);
    ld = 1'b0;
    wait_frame();
    check("hex_a_seg", seg_a, 7'b1110111);
    check("nohex_b_seg", seg_b, 7'h00);
    check("nohex_b_an", an_b, 4'b0001);

    // Lamp test dominates blanking; blanking darkens everything.
    lt = 1'b0; bi = 1'b0;
    skip(1);
    check("lt_seg", seg_a, 7'h7F);
    check("lt_dp", dp_a, 1'b1);
    check("lt_an_onehot", $onehot(an_a), 1);
    lt = 1'b1;
    skip(1);
    check("bi_seg", seg_a, 7'h00);
    check("bi_dp", dp_a, 1'b0);
    check("bi_an", an_a, 4'b0000);
    skip(3);
    check("bi_an_later", an_a, 4'b0000);
    bi = 1'b1;

    // Frame pulse width and period.
    wait_frame();
    skip(1);
    check("frame_width", fr_a, 1'b0);
    n = 1;
    while (fr_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_period", n, 16);

    // Load coincident with the wrap edge shows at idx0 of that frame.
    skip(15);
    ld = 1'b1; d = 16'h5678; dp_in = 4'b0001;
    skip(1);
    ld = 1'b0;
    check("coinc_frame", fr_a, 1'b1);
    check("coinc_seg", seg_a, 7'b1111111);
    check("coinc_dp", dp_a, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lt  = ($urandom % 12) != 0;
      bi  = ($urandom % 8) != 0;
      lzb = $urandom_range(0, 1);
      ld  = ($urandom % 10) == 0;
      for (int j = 0; j < 4; j++) rd[4*j +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
      d     = rd;
      dp_in = 4'($urandom);
    end

    // Asynchronous reset mid-frame at idx2.
    lt = 1'b1; bi = 1'b1; lzb = 1'b0; ld = 1'b0;
    wait_frame();
    skip(8);
    check("pre_rst_an", an_a, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", an_a, 4'b0000);
    check("async_rst_seg", seg_a, 7'h00);
    check("async_rst_dp", dp_a, 1'b0);
    check("async_rst_frame", fr_a, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_an", an_a, 4'b0001);
    check("post_rst_seg", seg_a, 7'b1111110);

    skip(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
